// File: rtl/quad_sample_ctrl.sv
// quad_sample_ctrl: sample-tick sequencer, zero offset and velocity for a quadrature counter.
// Define QUAD_VEL_AVG_EN to report velocity averaged over the last two periods.
module quad_sample_ctrl #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] count_in,
    input  logic             zero_req,
    input  logic             ovr_clr,
    output logic [CNT_W-1:0] pos_out,
    output logic [CNT_W-1:0] vel_out,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic             overrun,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [DIV_W-1:0] ONE_D = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] offset_q, offset_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] vel_q, vel_d;
    logic             first_q, first_d;
    logic             ovr_q, ovr_d;

    logic [DIV_W-1:0] div_eff;
    logic             active;
    logic             tick;
    logic             xfer;
    logic             load;
    logic             drop;
    logic             zero;
    logic [CNT_W-1:0] new_pos;
    logic [CNT_W-1:0] delta;
    logic [CNT_W-1:0] vel_calc;

`ifdef QUAD_VEL_AVG_EN
    logic [CNT_W-1:0] dprev_q, dprev_d;
    logic [CNT_W:0]   vel_sum;
`endif

    always_comb begin
        div_eff = (div == '0) ? ONE_D : div;
        active  = (state_q != IDLE);
        tick    = active && en && (timer_q == (div_eff - ONE_D));
        xfer    = (state_q == HOLD) && smp_ready;
        load    = tick && ((state_q == RUN) || xfer);
        drop    = tick && (state_q == HOLD) && !xfer;
        zero    = active && en && zero_req;
        new_pos = count_in - offset_q;
        delta   = new_pos - prev_q;
`ifdef QUAD_VEL_AVG_EN
        // Sign-extend both deltas so the halving is an arithmetic shift.
        vel_sum  = {delta[CNT_W-1], delta} + {dprev_q[CNT_W-1], dprev_q};
        vel_calc = vel_sum[CNT_W:1];
`else
        vel_calc = delta;
`endif
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        offset_d = offset_q;
        prev_d   = prev_q;
        pos_d    = pos_q;
        vel_d    = vel_q;
        first_d  = first_q;
        ovr_d    = ovr_q;
`ifdef QUAD_VEL_AVG_EN
        dprev_d  = dprev_q;
`endif

        unique case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN: begin
                if (!en)       state_d = IDLE;
                else if (tick) state_d = HOLD;
            end
            HOLD: begin
                if (!en)               state_d = IDLE;
                else if (xfer && !tick) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase

        if (!en || !active) timer_d = '0;
        else if (tick)      timer_d = '0;
        else                timer_d = timer_q + ONE_D;

        if (load) begin
            pos_d   = new_pos;
            vel_d   = first_q ? '0 : vel_calc;
            prev_d  = new_pos;
            first_d = 1'b0;
`ifdef QUAD_VEL_AVG_EN
            dprev_d = first_q ? '0 : delta;
`endif
        end

        // Zero after the sample so a coincident tick still uses the old offset.
        if (zero) begin
            offset_d = count_in;
            prev_d   = '0;
`ifdef QUAD_VEL_AVG_EN
            dprev_d  = '0;
`endif
        end

        if (!en) first_d = 1'b1;

        if (drop)         ovr_d = 1'b1;
        else if (ovr_clr) ovr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            offset_q <= '0;
            prev_q   <= '0;
            pos_q    <= '0;
            vel_q    <= '0;
            first_q  <= 1'b1;
            ovr_q    <= 1'b0;
`ifdef QUAD_VEL_AVG_EN
            dprev_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            offset_q <= offset_d;
            prev_q   <= prev_d;
            pos_q    <= pos_d;
            vel_q    <= vel_d;
            first_q  <= first_d;
            ovr_q    <= ovr_d;
`ifdef QUAD_VEL_AVG_EN
            dprev_q  <= dprev_d;
`endif
        end
    end

    assign pos_out   = pos_q;
    assign vel_out   = vel_q;
    assign smp_valid = (state_q == HOLD);
    assign overrun   = ovr_q;
    assign busy      = (state_q != IDLE);

endmodule
